stack_cache_window_ctrl: RTL and testbench
==========================================

Name: stack_cache_window_ctrl

Overview:
- Parametrised line-window controller for the stack cache.
- Keeps a ring of NUM_LINES line slots around the active stack line.
- Handles new-stack-pointer loads, push/pop line crossings, bound-limited prefetch and dirty-eviction waits.
- Sits between the stack datapath (which reports crossings and per-slot dirty status) and the memory fetch port.

Parameters:
- ADDR_W, 16, byte address width.
- LINE_OFF_W, 3, log2 line size in bytes (8-byte lines).
- NUM_LINES, 4, slot count; power of 2, minimum 4.
- PUSH_LINES, 1, slots kept on the push side of the head; pop side = NUM_LINES-1-PUSH_LINES (must be at least 1).

Ports:
- clk  in  1  clock
- async_rst_n  in  1  asynchronous reset, active low
- clk_en  in  1  global clock enable; state holds when 0
- new_sp_valid  in  1  load new stack pointer
- new_sp  in  ADDR_W  new stack pointer byte address
- push_bound  in  ADDR_W  highest permitted line address (line aligned)
- pop_bound  in  ADDR_W  lowest permitted line address (line aligned)
- push_cross  in  1  head moves +1 line
- pop_cross  in  1  head moves -1 line
- cross_ready  out  1  crossing accepted this cycle (= !busy)
- busy  out  1  window not settled
- head_slot  out  log2(NUM_LINES)  slot of the active line
- slot_valid  out  NUM_LINES  slot holds fetched, in-bounds line
- dirty  in  NUM_LINES  slot dirty, from datapath
- evict_req  out  NUM_LINES  one-hot; slot must be written back before reuse
- fetch_req_valid  out  1  fetch request
- fetch_req_ready  in  1  fetch handshake
- fetch_req_addr  out  ADDR_W  line address, low LINE_OFF_W bits zero
- fetch_req_slot  out  log2(NUM_LINES)  destination slot
- fetch_done_valid  in  1  fetch completion
- fetch_done_slot  in  log2(NUM_LINES)  completed slot

Behaviour:
- Reset: every output 0; all slot states INVALID; FSM in IDLE.
- Slot mapping is direct: slot = line_addr[LINE_OFF_W +: log2(NUM_LINES)].
- Window: lines head-POP_LINES..head+PUSH_LINES.
- Slot state per slot: INVALID, EVICT, PEND, FETCHING, VALID. slot_valid = (state==VALID).
- In bounds: pop_bound <= line <= push_bound, unsigned. An out-of-bounds window line goes INVALID and is never fetched.
- Fetch order on load: head, pop side nearest first, then push side nearest first.
- FSM states: IDLE, EVICT_WAIT, ISSUE, DRAIN.
- IDLE:
  - new_sp_valid: latch new head line; mark every in-bounds slot PEND; go to EVICT_WAIT.
  - Else accepted push_cross: head += 1 line; the slot of line head+PUSH_LINES (the old head-POP_LINES) becomes PEND if in bounds, else INVALID.
  - Else accepted pop_cross: symmetric, using line head-POP_LINES.
  - A crossing that creates a PEND slot goes to EVICT_WAIT.
  - If push_cross and pop_cross are both 1 in the same cycle, both are ignored.
- EVICT_WAIT: evict_req is asserted for every PEND slot whose dirty bit is 1. Stay until dirty & PEND-mask == 0, then go to ISSUE.
- ISSUE:
  - Present the next PEND slot in fetch order; fetch_req_valid=1 with addr and slot held stable until fetch_req_ready.
  - On handshake: that slot becomes FETCHING; the next request may go out the following cycle.
  - When no PEND slots remain, go to DRAIN.
- DRAIN: wait until no slot is FETCHING, then go to IDLE.
- fetch_done_valid marks the named slot VALID in any state. A done for a non-FETCHING slot is ignored.
- busy = (state != IDLE). It rises the cycle after the triggering event.
- new_sp_valid has priority over crossings and restarts the FSM from any state. FETCHING slots of the old window are dropped to INVALID, and their late dones are ignored.
- clk_en=0 freezes all state. Outputs stay registered.
- Async reset mid-operation: immediate return to reset values; no pending request survives.
- Address wrap: line arithmetic is modulo 2^ADDR_W; a wrapped line still passes through the bounds check.

Optional Feature:
- STACK_CACHE_PREPOP_EN adds input prepop (1 bit), sampled on new_sp_valid.
- prepop=1 shifts the load window one line toward push: lines head-POP_LINES+1..head+PUSH_LINES+1. The extra push line is fetched last. Crossing behaviour is unchanged; the shifted extents are kept until the next new_sp_valid.
- Without the macro: no port, fixed window.

Test Plan (NUM_LINES=4, PUSH_LINES=1, ADDR_W=16, 8-byte lines; pop_bound=0x0080, push_bound=0x0200 unless stated):
- Reset: async_rst_n=0 mid-ISSUE -> busy=0, slot_valid=0000, fetch_req_valid=0 immediately.
- Load: new_sp=0x0100 -> fetches 0x0100/s0, 0x00F8/s3, 0x00F0/s2, 0x0108/s1 in that order. After 4 dones: slot_valid=1111, head_slot=0, busy=0.
- Clean push: push_cross from that state -> head_slot=1, s2 refetched with 0x0110, slot_valid=1011 then 1111.
- Dirty evict: as above with dirty[2]=1 -> evict_req=0100 held, no fetch. Fetch of 0x0110 issues one cycle after dirty[2] falls.
- Bound: new_sp=0x0200, push_bound=0x0200 -> no fetch of 0x0208, s1 stays INVALID, slot_valid=1101.
- Restart: new_sp=0x0300 while FETCHING 0x00F8 -> old done ignored, new load order starts at 0x0300/s0.

Source files
------------

// File: rtl/stack_cache_window_ctrl_if.sv
// Memory fetch port of the stack cache window controller: request channel
// (valid/ready with line address and destination slot) plus completion strobe.
interface stack_cache_window_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int SLOT_W = 2
);
    logic              fetch_req_valid;
    logic              fetch_req_ready;
    logic [ADDR_W-1:0] fetch_req_addr;
    logic [SLOT_W-1:0] fetch_req_slot;
    logic              fetch_done_valid;
    logic [SLOT_W-1:0] fetch_done_slot;

    modport master (
        output fetch_req_valid, fetch_req_addr, fetch_req_slot,
        input  fetch_req_ready, fetch_done_valid, fetch_done_slot
    );

    modport slave (
        input  fetch_req_valid, fetch_req_addr, fetch_req_slot,
        output fetch_req_ready, fetch_done_valid, fetch_done_slot
    );
endinterface

// File: rtl/stack_cache_window_ctrl.sv
// Line-window controller for the stack cache: keeps a ring of NUM_LINES slots around the head line.
// Optional STACK_CACHE_PREPOP_EN adds a prepop input that shifts the load window one line toward push.
module stack_cache_window_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int LINE_OFF_W = 3,
    parameter int NUM_LINES  = 4,
    parameter int PUSH_LINES = 1
) (
    input  logic                         clk,
    input  logic                         async_rst_n,
    input  logic                         clk_en,
    input  logic                         new_sp_valid,
    input  logic [ADDR_W-1:0]            new_sp,
    input  logic [ADDR_W-1:0]            push_bound,
    input  logic [ADDR_W-1:0]            pop_bound,
    input  logic                         push_cross,
    input  logic                         pop_cross,
    output logic                         cross_ready,
    output logic                         busy,
    output logic [$clog2(NUM_LINES)-1:0] head_slot,
    output logic [NUM_LINES-1:0]         slot_valid,
    input  logic [NUM_LINES-1:0]         dirty,
    output logic [NUM_LINES-1:0]         evict_req,
`ifdef STACK_CACHE_PREPOP_EN
    input  logic                         prepop,
`endif
    stack_cache_window_ctrl_if.master    fetch
);
    localparam int SLOT_W    = $clog2(NUM_LINES);
    localparam int LINE_W    = ADDR_W - LINE_OFF_W;
    localparam int POP_LINES = NUM_LINES - 1 - PUSH_LINES;

    // Claimed slots wait in PEND while dirty data drains; EVICT is kept for encoding compatibility.
    typedef enum logic [2:0] {
        SLOT_INVALID, SLOT_EVICT, SLOT_PEND, SLOT_FETCHING, SLOT_VALID
    } slot_state_e;

    typedef enum logic [1:0] {
        ST_IDLE, ST_EVICT_WAIT, ST_ISSUE, ST_DRAIN
    } fsm_state_e;

    fsm_state_e        state_q, state_d;
    slot_state_e       slot_q [NUM_LINES];
    slot_state_e       slot_d [NUM_LINES];
    logic [LINE_W-1:0] head_q, head_d;
    logic              cross_ready_q;

    logic [SLOT_W-1:0] win_lo, win_hi;   // window extent below / above the head line
    logic [SLOT_W-1:0] load_lo;

    logic [LINE_W-1:0] pop_line, push_line;
    assign pop_line  = pop_bound[ADDR_W-1:LINE_OFF_W];
    assign push_line = push_bound[ADDR_W-1:LINE_OFF_W];

    logic unused_offset_bits;
    assign unused_offset_bits = ^{new_sp[LINE_OFF_W-1:0], pop_bound[LINE_OFF_W-1:0],
                                  push_bound[LINE_OFF_W-1:0]};

    function automatic logic in_bounds(input logic [LINE_W-1:0] line,
                                       input logic [LINE_W-1:0] lo,
                                       input logic [LINE_W-1:0] hi);
        return (line >= lo) && (line <= hi);
    endfunction

`ifdef STACK_CACHE_PREPOP_EN
    logic [SLOT_W-1:0] win_lo_q, win_lo_d, win_hi_q, win_hi_d;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            win_lo_q <= SLOT_W'(POP_LINES);
            win_hi_q <= SLOT_W'(PUSH_LINES);
        end else if (clk_en) begin
            win_lo_q <= win_lo_d;
            win_hi_q <= win_hi_d;
        end
    end

    assign win_lo   = win_lo_q;
    assign win_hi   = win_hi_q;
    assign load_lo  = prepop ? SLOT_W'(POP_LINES - 1) : SLOT_W'(POP_LINES);
    assign win_lo_d = new_sp_valid ? load_lo : win_lo_q;
    assign win_hi_d = new_sp_valid ? (prepop ? SLOT_W'(PUSH_LINES + 1) : SLOT_W'(PUSH_LINES))
                                   : win_hi_q;
`else
    assign win_lo  = SLOT_W'(POP_LINES);
    assign win_hi  = SLOT_W'(PUSH_LINES);
    assign load_lo = SLOT_W'(POP_LINES);
`endif

    logic [NUM_LINES-1:0] pend_mask;
    always_comb begin
        for (int s = 0; s < NUM_LINES; s++) begin
            pend_mask[s]  = (slot_q[s] == SLOT_PEND);
            slot_valid[s] = (slot_q[s] == SLOT_VALID);
        end
    end

    // Fetch order: head, then pop side nearest first, then push side nearest first.
    logic              req_found;
    logic [LINE_W-1:0] req_line, cand_line;
    logic [SLOT_W-1:0] req_slot;
    always_comb begin
        req_found = 1'b0;
        req_line  = '0;
        req_slot  = '0;
        cand_line = head_q;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (i == 0)                  cand_line = head_q;
            else if (i <= int'(win_lo))  cand_line = head_q - LINE_W'(i);
            else                         cand_line = head_q + LINE_W'(i - int'(win_lo));
            if (!req_found && slot_q[cand_line[SLOT_W-1:0]] == SLOT_PEND) begin
                req_found = 1'b1;
                req_line  = cand_line;
                req_slot  = cand_line[SLOT_W-1:0];
            end
        end
    end

    logic [LINE_W-1:0] new_line, load_head, load_base, load_line;
    logic [SLOT_W-1:0] load_off;
    logic              pend_left, fetching_left;

    // NOTE: every variable driven here gets a default first, otherwise paths that skip it infer latches.
    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        slot_d        = slot_q;
        new_line      = '0;
        load_head     = '0;
        load_base     = '0;
        load_line     = '0;
        load_off      = '0;
        pend_left     = 1'b0;
        fetching_left = 1'b0;

        if (fetch.fetch_done_valid && slot_q[fetch.fetch_done_slot] == SLOT_FETCHING)
            slot_d[fetch.fetch_done_slot] = SLOT_VALID;

        unique case (state_q)
            ST_IDLE: begin
                // Simultaneous push and pop crossings cancel and are ignored.
                if (cross_ready_q && (push_cross != pop_cross)) begin
                    if (push_cross) begin
                        head_d   = head_q + LINE_W'(1);
                        new_line = head_q + LINE_W'(1) + LINE_W'(win_hi);
                    end else begin
                        head_d   = head_q - LINE_W'(1);
                        new_line = head_q - LINE_W'(1) - LINE_W'(win_lo);
                    end
                    if (in_bounds(new_line, pop_line, push_line)) begin
                        slot_d[new_line[SLOT_W-1:0]] = SLOT_PEND;
                        state_d = ST_EVICT_WAIT;
                    end else begin
                        slot_d[new_line[SLOT_W-1:0]] = SLOT_INVALID;
                    end
                end
            end
            ST_EVICT_WAIT: if ((dirty & pend_mask) == '0) state_d = ST_ISSUE;
            ST_ISSUE:      if (req_found && fetch.fetch_req_ready) slot_d[req_slot] = SLOT_FETCHING;
            default: ;
        endcase

        for (int s = 0; s < NUM_LINES; s++) begin
            pend_left     = pend_left     | (slot_d[s] == SLOT_PEND);
            fetching_left = fetching_left | (slot_d[s] == SLOT_FETCHING);
        end
        if (state_q == ST_ISSUE && !pend_left)     state_d = ST_DRAIN;
        if (state_q == ST_DRAIN && !fetching_left) state_d = ST_IDLE;

        // A new stack pointer rebuilds the whole window; in-flight fetches are abandoned.
        if (new_sp_valid) begin
            load_head = new_sp[ADDR_W-1:LINE_OFF_W];
            load_base = load_head - LINE_W'(load_lo);
            for (int s = 0; s < NUM_LINES; s++) begin
                load_off  = SLOT_W'(s) - load_base[SLOT_W-1:0];
                load_line = load_base + LINE_W'(load_off);
                slot_d[s] = in_bounds(load_line, pop_line, push_line) ? SLOT_PEND : SLOT_INVALID;
            end
            head_d  = load_head;
            state_d = ST_EVICT_WAIT;
        end
    end

    // NOTE: the slot-state array is control state, not storage, so it is reset with the FSM.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q       <= ST_IDLE;
            head_q        <= '0;
            cross_ready_q <= 1'b0;
            for (int s = 0; s < NUM_LINES; s++) slot_q[s] <= SLOT_INVALID;
        end else if (clk_en) begin
            state_q       <= state_d;
            head_q        <= head_d;
            cross_ready_q <= (state_d == ST_IDLE);
            slot_q        <= slot_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign cross_ready = cross_ready_q;
    assign head_slot   = head_q[SLOT_W-1:0];
    assign evict_req   = (state_q == ST_EVICT_WAIT) ? (dirty & pend_mask) : '0;

    assign fetch.fetch_req_valid = (state_q == ST_ISSUE) && req_found;
    assign fetch.fetch_req_addr  = req_found ? {req_line, {LINE_OFF_W{1'b0}}} : '0;
    assign fetch.fetch_req_slot  = req_slot;
endmodule

// File: tb/tb_stack_cache_window_ctrl.sv
// Directed bench for stack_cache_window_ctrl: a cycle table for the first load,
// then hand-written crossing, eviction, bound, wrap, restart and reset sequences.
module tb_stack_cache_window_ctrl;
    logic        clk = 1'b0;
    logic        async_rst_n;
    logic        clk_en;
    logic        new_sp_valid;
    logic [15:0] new_sp, push_bound, pop_bound;
    logic        push_cross, pop_cross;
    logic        cross_ready, busy;
    logic [1:0]  head_slot;
    logic [3:0]  slot_valid, dirty, evict_req;
`ifdef STACK_CACHE_PREPOP_EN
    logic        prepop = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    stack_cache_window_ctrl_if #(.ADDR_W(16), .SLOT_W(2)) fif ();

    stack_cache_window_ctrl #(
        .ADDR_W(16), .LINE_OFF_W(3), .NUM_LINES(4), .PUSH_LINES(1)
    ) dut (
        .clk          (clk),
        .async_rst_n  (async_rst_n),
        .clk_en       (clk_en),
        .new_sp_valid (new_sp_valid),
        .new_sp       (new_sp),
        .push_bound   (push_bound),
        .pop_bound    (pop_bound),
        .push_cross   (push_cross),
        .pop_cross    (pop_cross),
        .cross_ready  (cross_ready),
        .busy         (busy),
        .head_slot    (head_slot),
        .slot_valid   (slot_valid),
        .dirty        (dirty),
        .evict_req    (evict_req),
`ifdef STACK_CACHE_PREPOP_EN
        .prepop       (prepop),
`endif
        .fetch        (fif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        nsv;
        logic [15:0] sp;
        logic        rdy;
        logic        dv;
        logic [1:0]  ds;
        logic        e_busy;
        logic        e_cr;
        logic [1:0]  e_head;
        logic [3:0]  e_sv;
        logic        e_frv;
        logic [15:0] e_addr;
        logic [1:0]  e_slot;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [15:0] sp);
        new_sp_valid = 1'b1;
        new_sp       = sp;
        tick();
        new_sp_valid = 1'b0;
    endtask

    task automatic expect_fetch(input string name, input logic [15:0] addr,
                                input logic [1:0] slot, input bit give_done);
        int n = 0;
        while (!fif.fetch_req_valid && n < 40) begin
            tick();
            n++;
        end
        check({name, " valid"}, 32'(fif.fetch_req_valid), 1);
        check({name, " addr"},  32'(fif.fetch_req_addr), 32'(addr));
        check({name, " slot"},  32'(fif.fetch_req_slot), 32'(slot));
        fif.fetch_req_ready = 1'b1;
        tick();
        fif.fetch_req_ready = 1'b0;
        if (give_done) begin
            fif.fetch_done_valid = 1'b1;
            fif.fetch_done_slot  = slot;
            tick();
            fif.fetch_done_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name, output bit saw_fetch);
        int n = 0;
        saw_fetch = 1'b0;
        while (busy && n < 40) begin
            if (fif.fetch_req_valid) saw_fetch = 1'b1;
            tick();
            n++;
        end
        check({name, " settled"}, 32'(busy), 0);
    endtask

    initial begin
        bit saw;

        // Load of 0x0100 from a cleared window, one row per clock.
        vecs[0] = '{1'b1, 16'h0100, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 16'h0000, 2'd0};
        vecs[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 16'h0100, 2'd0};
        vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 16'h0100, 2'd0};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 16'h00F8, 2'd3};
        vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 16'h00F0, 2'd2};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 16'h0108, 2'd1};
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b0, 16'h0000, 2'd0};
        vecs[7] = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 2'd0, 4'b1001, 1'b0, 16'h0000, 2'd0};
        vecs[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 4'b1101, 1'b0, 16'h0000, 2'd0};
        vecs[9] = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 16'h0000, 2'd0};

        async_rst_n          = 1'b0;
        clk_en               = 1'b1;
        new_sp_valid         = 1'b0;
        new_sp               = 16'h0000;
        pop_bound            = 16'h0080;
        push_bound           = 16'h0200;
        push_cross           = 1'b0;
        pop_cross            = 1'b0;
        dirty                = 4'b0000;
        fif.fetch_req_ready  = 1'b0;
        fif.fetch_done_valid = 1'b0;
        fif.fetch_done_slot  = 2'd0;

        #12;
        check("reset busy",        32'(busy), 0);
        check("reset cross_ready", 32'(cross_ready), 0);
        check("reset head_slot",   32'(head_slot), 0);
        check("reset slot_valid",  32'(slot_valid), 0);
        check("reset evict_req",   32'(evict_req), 0);
        check("reset fetch_valid", 32'(fif.fetch_req_valid), 0);
        check("reset fetch_addr",  32'(fif.fetch_req_addr), 0);

        @(negedge clk);
        async_rst_n = 1'b1;
        tick();
        check("post-reset cross_ready", 32'(cross_ready), 1);
        tick();

        for (int i = 0; i < 10; i++) begin
            new_sp_valid         = vecs[i].nsv;
            new_sp               = vecs[i].sp;
            fif.fetch_req_ready  = vecs[i].rdy;
            fif.fetch_done_valid = vecs[i].dv;
            fif.fetch_done_slot  = vecs[i].ds;
            tick();
            check($sformatf("vec%0d busy", i),        32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d cross_ready", i), 32'(cross_ready), 32'(vecs[i].e_cr));
            check($sformatf("vec%0d head_slot", i),   32'(head_slot), 32'(vecs[i].e_head));
            check($sformatf("vec%0d slot_valid", i),  32'(slot_valid), 32'(vecs[i].e_sv));
            check($sformatf("vec%0d fetch_valid", i), 32'(fif.fetch_req_valid), 32'(vecs[i].e_frv));
            if (vecs[i].e_frv) begin
                check($sformatf("vec%0d fetch_addr", i), 32'(fif.fetch_req_addr), 32'(vecs[i].e_addr));
                check($sformatf("vec%0d fetch_slot", i), 32'(fif.fetch_req_slot), 32'(vecs[i].e_slot));
            end
        end
        new_sp_valid         = 1'b0;
        fif.fetch_req_ready  = 1'b0;
        fif.fetch_done_valid = 1'b0;

        // Clean push: head moves to slot 1, slot 2 refetched with line 0x0110.
        push_cross = 1'b1;
        tick();
        push_cross = 1'b0;
        check("push head_slot",  32'(head_slot), 1);
        check("push slot_valid", 32'(slot_valid), 'hB);
        check("push busy",       32'(busy), 1);
        check("push cross_ready", 32'(cross_ready), 0);
        expect_fetch("push fetch", 16'h0110, 2'd2, 1'b1);
        wait_idle("push", saw);
        check("push final slot_valid", 32'(slot_valid), 'hF);

        // Push and pop together are both ignored.
        push_cross = 1'b1;
        pop_cross  = 1'b1;
        tick();
        push_cross = 1'b0;
        pop_cross  = 1'b0;
        check("both-cross busy",      32'(busy), 0);
        check("both-cross head_slot", 32'(head_slot), 1);
        check("both-cross slot_valid", 32'(slot_valid), 'hF);

        // Pop back: head returns to slot 0, slot 2 refetched with line 0x00F0.
        pop_cross = 1'b1;
        tick();
        pop_cross = 1'b0;
        check("pop head_slot",  32'(head_slot), 0);
        check("pop slot_valid", 32'(slot_valid), 'hB);
        expect_fetch("pop fetch", 16'h00F0, 2'd2, 1'b1);
        wait_idle("pop", saw);
        check("pop final slot_valid", 32'(slot_valid), 'hF);

        // Dirty eviction: slot 2 held until its dirty bit clears.
        dirty      = 4'b0100;
        push_cross = 1'b1;
        tick();
        push_cross = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("evict%0d evict_req", i),   32'(evict_req), 'h4);
            check($sformatf("evict%0d fetch_valid", i), 32'(fif.fetch_req_valid), 0);
            tick();
        end
        dirty = 4'b0000;
        tick();
        check("evict release fetch_valid", 32'(fif.fetch_req_valid), 1);
        check("evict release evict_req",   32'(evict_req), 0);
        expect_fetch("evict fetch", 16'h0110, 2'd2, 1'b1);
        wait_idle("evict", saw);
        check("evict final slot_valid", 32'(slot_valid), 'hF);

        // Clock enable low: a load request is not seen.
        clk_en = 1'b0;
        start_load(16'h0180);
        tick();
        check("clk_en busy",       32'(busy), 0);
        check("clk_en head_slot",  32'(head_slot), 1);
        check("clk_en slot_valid", 32'(slot_valid), 'hF);
        clk_en = 1'b1;

        // Push bound: line 0x0208 is out of range and never fetched.
        start_load(16'h0200);
        expect_fetch("bound f0", 16'h0200, 2'd0, 1'b1);
        expect_fetch("bound f1", 16'h01F8, 2'd3, 1'b1);
        expect_fetch("bound f2", 16'h01F0, 2'd2, 1'b1);
        wait_idle("bound", saw);
        check("bound no extra fetch", 32'(saw), 0);
        check("bound slot_valid",     32'(slot_valid), 'hD);
        check("bound head_slot",      32'(head_slot), 0);

        // Address wrap: the wrapped push line 0x0000 falls below pop_bound.
        pop_bound  = 16'h0008;
        push_bound = 16'hFFF8;
        start_load(16'hFFF8);
        expect_fetch("wrap f0", 16'hFFF8, 2'd3, 1'b1);
        expect_fetch("wrap f1", 16'hFFF0, 2'd2, 1'b1);
        expect_fetch("wrap f2", 16'hFFE8, 2'd1, 1'b1);
        wait_idle("wrap", saw);
        check("wrap no extra fetch", 32'(saw), 0);
        check("wrap slot_valid",     32'(slot_valid), 'hE);
        check("wrap head_slot",      32'(head_slot), 3);

        // Restart while 0x00F8 is in flight; its late done must be ignored.
        pop_bound  = 16'h0080;
        push_bound = 16'h0400;
        start_load(16'h0100);
        expect_fetch("restart old f0", 16'h0100, 2'd0, 1'b0);
        expect_fetch("restart old f1", 16'h00F8, 2'd3, 1'b0);
        start_load(16'h0300);
        check("restart busy",       32'(busy), 1);
        check("restart slot_valid", 32'(slot_valid), 0);
        fif.fetch_done_valid = 1'b1;
        fif.fetch_done_slot  = 2'd3;
        tick();
        fif.fetch_done_slot  = 2'd0;
        tick();
        fif.fetch_done_valid = 1'b0;
        check("restart late done ignored", 32'(slot_valid), 0);
        expect_fetch("restart f0", 16'h0300, 2'd0, 1'b1);
        expect_fetch("restart f1", 16'h02F8, 2'd3, 1'b1);
        expect_fetch("restart f2", 16'h02F0, 2'd2, 1'b1);
        expect_fetch("restart f3", 16'h0308, 2'd1, 1'b1);
        wait_idle("restart", saw);
        check("restart final slot_valid", 32'(slot_valid), 'hF);
        check("restart head_slot",        32'(head_slot), 0);

        // Asynchronous reset in the middle of ISSUE.
        push_cross = 1'b1;
        tick();
        push_cross = 1'b0;
        tick();
        check("pre-reset fetch_valid", 32'(fif.fetch_req_valid), 1);
        #2;
        async_rst_n = 1'b0;
        #1;
        check("async reset busy",        32'(busy), 0);
        check("async reset slot_valid",  32'(slot_valid), 0);
        check("async reset fetch_valid", 32'(fif.fetch_req_valid), 0);
        check("async reset head_slot",   32'(head_slot), 0);
        check("async reset cross_ready", 32'(cross_ready), 0);
        @(negedge clk);
        async_rst_n = 1'b1;
        tick();
        tick();
        check("after reset busy",        32'(busy), 0);
        check("after reset fetch_valid", 32'(fif.fetch_req_valid), 0);
        check("after reset slot_valid",  32'(slot_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
